// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fields in, datapath controls out; master = controller, slave = datapath
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       pcWrite;
  logic       adrSrc;
  logic       memWrite;
  logic       irWrite;
  logic       regWrite;
  logic [1:0] resultSrc;
  logic [1:0] aluSrcA;
  logic [1:0] aluSrcB;
  logic [2:0] aluControl;
  logic [2:0] immSrc;
  logic [3:0] state;
  modport master (
    input  op, funct3, funct7b5, zero,
    output pcWrite, adrSrc, memWrite, irWrite, regWrite,
           resultSrc, aluSrcA, aluSrcB, aluControl, immSrc, state
  );
  modport slave (
    output op, funct3, funct7b5, zero,
    input  pcWrite, adrSrc, memWrite, irWrite, regWrite,
           resultSrc, aluSrcA, aluSrcB, aluControl, immSrc, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: RV32 multicycle FSM (clk, rst, bus.master: op/funct3/funct7b5/zero in, datapath controls + state out); RV_UTYPE_EN enables lui
module multicycle_controller (
  input logic clk,
  input logic rst,
  multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, LUI
  } state_t;
`ifdef RV_UTYPE_EN
  localparam logic UT = 1'b1;
`else
  localparam logic UT = 1'b0;
`endif
  state_t st, nx, s;
  logic [2:0] alu_dec;
  logic pc_w, mem_w, ir_w, reg_w, adr;
  logic [1:0] res, sa, sb;
  logic [2:0] ac;
  always_ff @(posedge clk)
    st <= rst ? FETCH : nx;
  always_comb begin
    nx = FETCH;
    case (st)
      FETCH:  nx = DECODE;
      DECODE: case (bus.op)
        7'b0000011, 7'b0100011: nx = MEMADR;
        7'b0110011: nx = EXECR;
        7'b0010011: nx = EXECI;
        7'b1100011: nx = BRANCH;
        7'b1101111: nx = JAL;
        7'b0110111: nx = UT ? LUI : FETCH;
        default:    nx = FETCH;
      endcase
      MEMADR:  nx = bus.op == 7'b0000011 ? MEMREAD : MEMWRITE;
      MEMREAD: nx = MEMWB;
      EXECR, EXECI, JAL: nx = ALUWB;
      LUI:     nx = UT ? ALUWB : FETCH;
      default: nx = FETCH;
    endcase
  end
  // reset shows FETCH muxing with every write enable masked
  assign s = rst ? FETCH : st;
  assign alu_dec = bus.funct3 == 3'b000 ? ((s == EXECR && bus.funct7b5) ? 3'b001 : 3'b000) :
                   bus.funct3 == 3'b111 ? 3'b010 :
                   bus.funct3 == 3'b110 ? 3'b011 :
                   bus.funct3 == 3'b010 ? 3'b101 : 3'b000;
  always_comb begin
    pc_w = 1'b0; mem_w = 1'b0; ir_w = 1'b0; reg_w = 1'b0; adr = 1'b0;
    res = 2'b00; sa = 2'b00; sb = 2'b00; ac = 3'b000;
    case (s)
      FETCH:    begin ir_w = 1'b1; sb = 2'b10; res = 2'b10; pc_w = 1'b1; end
      DECODE:   begin sa = 2'b01; sb = 2'b01; end
      MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      MEMREAD:  adr = 1'b1;
      MEMWB:    begin res = 2'b01; reg_w = 1'b1; end
      MEMWRITE: begin adr = 1'b1; mem_w = 1'b1; end
      EXECR:    begin sa = 2'b10; ac = alu_dec; end
      EXECI:    begin sa = 2'b10; sb = 2'b01; ac = alu_dec; end
      ALUWB:    reg_w = 1'b1;
      BRANCH:   begin
        sa = 2'b10; ac = 3'b001;
        pc_w = (bus.funct3 == 3'b000 && bus.zero) || (bus.funct3 == 3'b001 && !bus.zero);
      end
      JAL:      begin sa = 2'b01; sb = 2'b10; pc_w = 1'b1; end
      LUI:      if (UT) begin sa = 2'b11; sb = 2'b01; end
      default:  ;
    endcase
  end
  assign bus.pcWrite    = pc_w & ~rst;
  assign bus.memWrite   = mem_w & ~rst;
  assign bus.irWrite    = ir_w & ~rst;
  assign bus.regWrite   = reg_w & ~rst;
  assign bus.adrSrc     = adr;
  assign bus.resultSrc  = res;
  assign bus.aluSrcA    = sa;
  assign bus.aluSrcB    = sb;
  assign bus.aluControl = ac;
  assign bus.state      = st;
  assign bus.immSrc = bus.op == 7'b0100011 ? 3'b001 :
                      bus.op == 7'b1100011 ? 3'b010 :
                      bus.op == 7'b1101111 ? 3'b011 :
                      (UT && bus.op == 7'b0110111) ? 3'b100 : 3'b000;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of state sequencing and control decode
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int passed = 0;
  multicycle_controller_if bus ();
  multicycle_controller dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  function automatic logic [7:0] we();
    return {4'b0, bus.pcWrite, bus.memWrite, bus.irWrite, bus.regWrite};
  endfunction
  initial begin
    rst = 1'b1;
    bus.op = 7'b0000011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    repeat (2) @(posedge clk);
    tick();
    chk("rst_state", 8'(bus.state), 8'd0);
    chk("rst_we", we(), 8'h00);
    chk("rst_srcb", 8'(bus.aluSrcB), 8'd2);
    chk("rst_res", 8'(bus.resultSrc), 8'd2);
    rst = 1'b0;
    #1;
    chk("fetch_we", we(), 8'h0a);
    chk("lw_imm", 8'(bus.immSrc), 8'd0);
    tick(); chk("lw_s1", 8'(bus.state), 8'd1); chk("dec_srca", 8'(bus.aluSrcA), 8'd1);
    chk("dec_we", we(), 8'h00);
    tick(); chk("lw_s2", 8'(bus.state), 8'd2); chk("madr_srca", 8'(bus.aluSrcA), 8'd2);
    tick(); chk("lw_s3", 8'(bus.state), 8'd3); chk("mread_adr", 8'(bus.adrSrc), 8'd1);
    chk("mread_we", we(), 8'h00);
    tick(); chk("lw_s4", 8'(bus.state), 8'd4); chk("mwb_we", we(), 8'h01);
    chk("mwb_res", 8'(bus.resultSrc), 8'd1);
    tick(); chk("lw_s0", 8'(bus.state), 8'd0);
    bus.op = 7'b1100011; bus.funct3 = 3'b001; bus.zero = 1'b0;
    #1 chk("br_imm", 8'(bus.immSrc), 8'd2);
    tick(); tick(); chk("br_s9", 8'(bus.state), 8'd9);
    chk("bne_taken", 8'(bus.pcWrite), 8'd1); chk("br_alu", 8'(bus.aluControl), 8'd1);
    tick(); chk("br_s0", 8'(bus.state), 8'd0);
    bus.zero = 1'b1;
    tick(); tick(); chk("bne_nt", 8'(bus.pcWrite), 8'd0);
    bus.funct3 = 3'b000;
    #1 chk("beq_taken", 8'(bus.pcWrite), 8'd1);
    tick();
    bus.op = 7'b0110011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b1;
    tick(); tick(); chk("r_s6", 8'(bus.state), 8'd6); chk("r_sub", 8'(bus.aluControl), 8'd1);
    bus.funct3 = 3'b110;
    #1 chk("r_or", 8'(bus.aluControl), 8'd3);
    bus.funct3 = 3'b010;
    #1 chk("r_slt", 8'(bus.aluControl), 8'd5);
    tick(); chk("r_s8", 8'(bus.state), 8'd8); chk("aluwb_we", we(), 8'h01);
    tick(); chk("r_s0", 8'(bus.state), 8'd0);
    bus.op = 7'b0010011; bus.funct3 = 3'b000; bus.funct7b5 = 1'b1;
    tick(); tick(); chk("i_s7", 8'(bus.state), 8'd7); chk("i_add", 8'(bus.aluControl), 8'd0);
    bus.funct3 = 3'b111;
    #1 chk("i_and", 8'(bus.aluControl), 8'd2);
    tick(); tick(); chk("i_s0", 8'(bus.state), 8'd0);
    bus.op = 7'b0100011;
    tick(); tick(); tick(); chk("sw_s5", 8'(bus.state), 8'd5);
    chk("sw_we", we(), 8'h04); chk("sw_imm", 8'(bus.immSrc), 8'd1);
    rst = 1'b1;
    #1 chk("sw_rst_we", we(), 8'h00);
    tick(); chk("sw_rst_s0", 8'(bus.state), 8'd0);
    rst = 1'b0;
    bus.op = 7'b1101111;
    tick(); tick(); chk("jal_s10", 8'(bus.state), 8'd10); chk("jal_we", we(), 8'h08);
    chk("jal_imm", 8'(bus.immSrc), 8'd3);
    tick(); tick(); chk("jal_s0", 8'(bus.state), 8'd0);
    bus.op = 7'b0110111;
    tick(); tick();
`ifdef RV_UTYPE_EN
    chk("lui_imm", 8'(bus.immSrc), 8'd4);
    chk("lui_s11", 8'(bus.state), 8'd11); chk("lui_srca", 8'(bus.aluSrcA), 8'd3);
    tick(); chk("lui_s8", 8'(bus.state), 8'd8);
    tick(); chk("lui_s0", 8'(bus.state), 8'd0);
`else
    chk("lui_imm", 8'(bus.immSrc), 8'd0);
    chk("lui_ill_s0", 8'(bus.state), 8'd0);
    chk("lui_ill_we", 8'(bus.regWrite), 8'd0);
`endif
    bus.op = 7'b1111111;
    tick(); chk("ill_s1", 8'(bus.state), 8'd1); chk("ill_dec_we", we(), 8'h00);
    tick(); chk("ill_s0", 8'(bus.state), 8'd0);
    tick(); chk("ill_s1b", 8'(bus.state), 8'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have exactly these ports: clk, input, 1, rising-edge clock.
REQ-002 The block SHALL have exactly these ports: rst, input, 1, synchronous active-high reset.
REQ-003 The block SHALL have exactly these ports: op, input, 7, instruction opcode.
REQ-004 The block SHALL have exactly these ports: funct3, input, 3, instruction funct3.
REQ-005 The block SHALL have exactly these ports: funct7b5, input, 1, instruction bit 30.
REQ-006 The block SHALL have exactly these ports: zero, input, 1, ALU zero flag.
REQ-007 The block SHALL have exactly these ports: pcWrite, adrSrc, memWrite, irWrite and regWrite, output, 1 each, datapath enables and selects.
REQ-008 The block SHALL have exactly these ports: resultSrc, aluSrcA and aluSrcB, output, 2 each, result and ALU operand muxes.
REQ-009 The block SHALL have exactly these ports: aluControl, output, 3, coded 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-010 The block SHALL have exactly these ports: immSrc, output, 3, extender format: 000 I, 001 S, 010 B, 011 J, 100 U.
REQ-011 The block SHALL have exactly these ports: state, output, 4, current state for debug.

Function
REQ-012 The state encoding SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, LUI=11.
REQ-013 The next-state transitions SHALL be:
- FETCH->DECODE.
- DECODE by op: 0000011/0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1100011->BRANCH; 1101111->JAL; 0110111->LUI; any other op->FETCH (illegal opcode, no side effects).
- MEMADR->MEMREAD if op=0000011, else ->MEMWRITE.
- MEMREAD->MEMWB.
- EXECR, EXECI, JAL and LUI->ALUWB.
- MEMWB, MEMWRITE, ALUWB and BRANCH->FETCH.
REQ-014 Outputs SHALL be Moore-decoded from state, except branch pcWrite and immSrc; every unlisted output SHALL be 0.
REQ-015 FETCH SHALL assert adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, aluControl=add, resultSrc=10 and pcWrite=1.
REQ-016 DECODE SHALL assert aluSrcA=01 and aluSrcB=01 with aluControl=add, precomputing the branch/jump target.
REQ-017 MEMADR SHALL assert aluSrcA=10, aluSrcB=01 and add.
REQ-018 MEMREAD SHALL assert resultSrc=00 and adrSrc=1; MEMWB SHALL assert resultSrc=01 and regWrite=1; MEMWRITE SHALL assert resultSrc=00, adrSrc=1 and memWrite=1.
REQ-019 EXECR SHALL assert aluSrcA=10 and aluSrcB=00; EXECI SHALL assert aluSrcA=10 and aluSrcB=01.
REQ-020 ALUWB SHALL assert resultSrc=00 and regWrite=1.
REQ-021 BRANCH SHALL assert aluSrcA=10, aluSrcB=00, aluControl=sub and resultSrc=00; pcWrite SHALL be (funct3=000 & zero) | (funct3=001 & ~zero) in the same cycle.
REQ-022 JAL SHALL assert aluSrcA=01, aluSrcB=10, add, resultSrc=00 and pcWrite=1.
REQ-023 LUI SHALL assert aluSrcA=11 (zero operand), aluSrcB=01 and add.
REQ-024 aluControl in EXECR/EXECI SHALL be: funct3 000 -> sub if EXECR and funct7b5=1, else add; 111->and; 110->or; 010->slt; any other->add.
REQ-025 immSrc SHALL be combinational from op in all states: 0100011->001; 1100011->010; 1101111->011; 0110111->100; otherwise 000.
REQ-026 Instruction latency SHALL be: lw 5 cycles; sw, R-type, I-type, jal and lui 4 cycles; branch 3 cycles.

Reset
REQ-027 With rst=1 at a clk edge, state SHALL become FETCH, overriding any in-progress instruction including MEMWRITE.
REQ-028 While rst=1, memWrite, regWrite, pcWrite and irWrite SHALL be forced to 0; all other outputs SHALL take FETCH values.

Configuration
REQ-029 The macro RV_UTYPE_EN SHALL gate U-type support.
REQ-030 With RV_UTYPE_EN defined, the LUI state and op 0110111 SHALL behave as above.
REQ-031 Without RV_UTYPE_EN, op 0110111 SHALL be illegal (DECODE->FETCH), immSrc SHALL be 000 for it, and state 11 SHALL never be entered (if reached, ->FETCH).

Verification
REQ-032 Release reset with op=0000011 -> state sequence 0,1,2,3,4,0; regWrite=1 only in state 4; immSrc=000.
REQ-033 op=1100011, funct3=001, zero=0 in BRANCH -> pcWrite=1, aluControl=001, immSrc=010; repeat with zero=1 -> pcWrite=0.
REQ-034 op=0110011, funct3=000, funct7b5=1 -> EXECR aluControl=001; op=0010011 with the same fields -> EXECI aluControl=000.
REQ-035 op=0100011, rst=1 asserted in MEMWRITE -> next state 0, memWrite=0 in the reset cycle.
REQ-036 op=0110111 -> with RV_UTYPE_EN: states 0,1,11,8,0, immSrc=100; without it: states 0,1,0, no regWrite.
REQ-037 op=1111111 -> DECODE->FETCH, no write enables asserted.
